// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: write n, pulse go, poll status, read n!.
// One multiply per cycle; RD is a combinational read port into the SoC read mux.
module fact_accel #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WE,
  input  logic [1:0]       A,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD
);

  localparam int unsigned MAXN = 12;

  localparam logic [1:0] ADDR_N      = 2'b00;
  localparam logic [1:0] ADDR_GO     = 2'b01;
  localparam logic [1:0] ADDR_STATUS = 2'b10;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, state_d;
  logic [NBITS-1:0]   n, n_d;
  logic [NBITS-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   result, result_d;
  logic               done, done_d;
  logic               err, err_d;
  logic               busy;

  // Only the operand field and go bit of WD are architecturally meaningful.
  logic unused_wd;
  assign unused_wd = ^WD[WIDTH-1:NBITS];

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      n      <= '0;
      cnt    <= '0;
      acc    <= WIDTH'(1);
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      n      <= n_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      result <= result_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    n_d      = n;
    cnt_d    = cnt;
    acc_d    = acc;
    result_d = result;
    done_d   = done;
    err_d    = err;
    unique case (state)
      IDLE: begin
        if (WE && (A == ADDR_N)) begin
          n_d = WD[NBITS-1:0];
        end
        if (WE && (A == ADDR_GO) && WD[0]) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n > NBITS'(MAXN)) begin
            // Out-of-range operand: flag immediately, never enter CALC.
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            acc_d   = WIDTH'(1);
            cnt_d   = n;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt <= NBITS'(1)) begin
          result_d = acc;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          acc_d = acc * WIDTH'(cnt);
          cnt_d = cnt - NBITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    RD = '0;
    unique case (A)
      ADDR_N:      RD = WIDTH'(n);
      ADDR_GO:     RD = WIDTH'(busy);
      ADDR_STATUS: RD = WIDTH'({err, done});
      default:     RD = result;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed self-checking bench for fact_accel with hand-computed factorials.
module tb_fact_accel;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [1:0]  A;
  logic [31:0] WD;
  logic [31:0] RD;

  int checks;
  int errors;

  fact_accel #(.NBITS(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .WE  (WE),
    .A   (A),
    .WD  (WD),
    .RD  (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; returns at the falling edge after the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1;
    A  = a;
    WD = d;
    @(negedge clk);
    WE = 1'b0;
    WD = '0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    WE = 1'b0;
    A  = a;
    #1;
    check(tag, RD, exp);
  endtask

  task automatic edges(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    WE  = 1'b0;
    A   = 2'b00;
    WD  = '0;
    edges(2);
    rst = 1'b0;

    read_check("rst_n",      2'd0, 32'd0);
    read_check("rst_busy",   2'd1, 32'd0);
    read_check("rst_status", 2'd2, 32'd0);
    read_check("rst_result", 2'd3, 32'd0);

    // Read during a write sees the pre-edge value.
    @(negedge clk);
    WE = 1'b1; A = 2'd0; WD = 32'd7;
    #1;
    check("rd_pre_edge", RD, 32'd0);
    @(negedge clk);
    WE = 1'b0;
    read_check("rd_post_edge", 2'd0, 32'd7);

    // Writes to status are ignored; go with WD[0]=0 does nothing.
    bus_write(2'd2, 32'd3);
    read_check("status_wr_ign", 2'd2, 32'd0);
    bus_write(2'd1, 32'd2);
    read_check("go0_busy", 2'd1, 32'd0);

    // n=5: busy for 5 cycles, done after edge k+5.
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      read_check("n5_busy",   2'd1, 32'd1);
      read_check("n5_status", 2'd2, 32'd0);
      edges(1);
    end
    read_check("n5_done",   2'd2, 32'd1);
    read_check("n5_idle",   2'd1, 32'd0);
    read_check("n5_result", 2'd3, 32'd120);

    // n=0 and n=1 both finish one edge after start.
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd1);
    read_check("n0_status0", 2'd2, 32'd0);
    edges(1);
    read_check("n0_status1", 2'd2, 32'd1);
    read_check("n0_result",  2'd3, 32'd1);

    bus_write(2'd0, 32'd1);
    bus_write(2'd1, 32'd1);
    read_check("n1_status0", 2'd2, 32'd0);
    edges(1);
    read_check("n1_status1", 2'd2, 32'd1);
    read_check("n1_result",  2'd3, 32'd1);

    // n=12: largest legal operand.
    bus_write(2'd0, 32'd12);
    bus_write(2'd1, 32'd1);
    edges(11);
    read_check("n12_status0", 2'd2, 32'd0);
    read_check("n12_busy",    2'd1, 32'd1);
    edges(1);
    read_check("n12_status1", 2'd2, 32'd1);
    read_check("n12_result",  2'd3, 32'h1C8C_FC00);

    // n=13: error reported at the start edge, result cleared, never busy.
    bus_write(2'd0, 32'd13);
    bus_write(2'd1, 32'd1);
    read_check("n13_status", 2'd2, 32'd3);
    read_check("n13_result", 2'd3, 32'd0);
    read_check("n13_busy",   2'd1, 32'd0);

    // n=6 with writes to n and go during CALC, both ignored.
    bus_write(2'd0, 32'd6);
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'd1);
    read_check("n6_keep_n", 2'd0, 32'd6);
    read_check("n6_err_clr", 2'd2, 32'd0);
    edges(3);
    read_check("n6_status0", 2'd2, 32'd0);
    edges(1);
    read_check("n6_status1", 2'd2, 32'd1);
    read_check("n6_result",  2'd3, 32'h2D0);
    read_check("n6_n_after", 2'd0, 32'd6);

    // Back-to-back n=4; result holds 24 across the restart.
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd1);
    edges(4);
    read_check("b2b_done1",   2'd2, 32'd1);
    read_check("b2b_result1", 2'd3, 32'd24);
    bus_write(2'd1, 32'd1);
    read_check("b2b_status0", 2'd2, 32'd0);
    read_check("b2b_busy",    2'd1, 32'd1);
    read_check("b2b_hold0",   2'd3, 32'd24);
    edges(3);
    read_check("b2b_status3", 2'd2, 32'd0);
    read_check("b2b_hold3",   2'd3, 32'd24);
    edges(1);
    read_check("b2b_done2",   2'd2, 32'd1);
    read_check("b2b_result2", 2'd3, 32'd24);

    // Reset mid-CALC (n=10), with a simultaneous write that reset must override.
    bus_write(2'd0, 32'd10);
    bus_write(2'd1, 32'd1);
    edges(3);
    rst = 1'b1;
    WE = 1'b1; A = 2'd0; WD = 32'd9;
    @(negedge clk);
    rst = 1'b0;
    WE = 1'b0;
    read_check("rstc_busy",   2'd1, 32'd0);
    read_check("rstc_status", 2'd2, 32'd0);
    read_check("rstc_result", 2'd3, 32'd0);
    read_check("rstc_n",      2'd0, 32'd0);
    edges(12);
    read_check("rstc_noresume", 2'd2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped iterative factorial accelerator on the SoC data bus.
- Software writes an operand n, pulses a start bit, polls status, then reads the 32-bit result n!.
- Its read-data output RD is one input of the SoC read-data select mux, alongside data memory and GPIO.
- Single clock domain, one multiply per cycle.

Parameters:
- NBITS, 4, width of operand register n. Legal operands are 0..12, because 13! overflows 32 bits.
- WIDTH, 32, bus data width and result width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- WE  input  1  write enable, qualified by the SoC address decoder.
- A  input  2  register select (word offset).
- WD  input  WIDTH  write data.
- RD  output  WIDTH  read data, combinational from A and internal registers.

Behaviour:
- Register map:
  - A=00 n: write latches WD[NBITS-1:0]; read returns {zero-pad, n}.
  - A=01 go: write with WD[0]=1 starts a computation; read returns {31'b0, busy}.
  - A=10 status: read-only, returns {30'b0, err, done}; writes ignored.
  - A=11 result: read-only; writes ignored.
- Reset (rst=1 at an edge): state=IDLE, n=0, acc=1, cnt=0, result=0, done=0, err=0, busy=0. Reset wins over any simultaneous write. Reset mid-computation aborts it with no partial result.
- FSM states:
  - IDLE: busy=0.
  - CALC: busy=1.
- IDLE, write A=00: n updates at that edge.
- IDLE, write A=01 with WD[0]=1 (start edge k): done<=0, err<=0.
  - If n>12: err<=1, done<=1, result<=0, stay IDLE.
  - Else: acc<=1, cnt<=n, state<=CALC.
- IDLE, write A=01 with WD[0]=0: no effect.
- CALC at each edge:
  - If cnt<=1: result<=acc, done<=1, state<=IDLE.
  - Else: acc<=acc*cnt (low WIDTH bits), cnt<=cnt-1.
- Latency from start edge k:
  - done visible after edge k+n for n>=2.
  - done visible after edge k+1 for n in {0,1}.
  - done visible after edge k for the error case.
- While busy, writes to n and go are ignored: n keeps its old value and the computation is not restarted.
- result holds its value until the next successful completion, an error start, or reset.
- done and err are sticky until the next accepted start or reset.
- Writing go when already done starts a fresh computation and clears done/err on that edge.
- Multiply width: cnt is zero-extended to WIDTH. The product never exceeds 32 bits for legal n, so no overflow detection is needed beyond the n>12 check.
- RD is purely combinational.
  - A read in the same cycle as a write returns the pre-edge value.
  - Unused upper bits read 0.

Test Plan:
- Reset then read all four addresses -> RD = 0, 0, 0, 0. Assert rst mid-CALC (n=10) -> next cycle busy=0, done=0, result=0.
- Write n=5, write go=1 -> busy=1 for 5 cycles; status=0x1 after edge k+5; result=0x00000078 (120).
- n=0 and n=1, each started -> status=0x1 after 1 cycle, result=1 in both cases.
- n=12 -> result=0x1C8CFC00 (479001600) after 12 cycles. Then n=13 -> status=0x3 the next cycle, result=0, busy never set.
- During CALC for n=6, write n=3 and go=1 -> both ignored; result=720 (0x2D0); reading A=00 returns 6.
- Back-to-back: complete n=4 (result=24), immediately write go=1 with n=4 -> done reads 0 on the next cycle, then returns to 1 after 4 cycles; result stays 24 throughout.
